// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Sequential PC step; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(2);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, or flush to a NOP bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [15:0]     instr_in,
    input  logic [PC_W-1:0] pc_plus2_in,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] pc_plus2,
    output logic            valid
);

    // Flush takes priority over load; neither asserted means hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus2 <= pc_plus2_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, RUN/HALTED control and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_stall,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_id,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        fetch_halted
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic            ifid_load, ifid_flush;

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= PC_RESET;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Per-edge priority: redirect, decode stall, halt, memory stall, fetch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (stall_id) begin
                    // hold PC and IF/ID; a pending halt is re-evaluated next cycle
                end else if (halt_id) begin
                    state_next = HALTED;
                    ifid_flush = 1'b1;
                end else if (imem_stall) begin
                    ifid_flush = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    pc_next   = pc_inc(pc);
                end
            end
            HALTED: begin
                // A redirect here means the halt was on a wrong path.
                if (redirect) begin
                    state_next = RUN;
                    pc_next    = redirect_pc;
                    ifid_flush = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign imem_addr    = pc;
    assign imem_rd      = (state == RUN) && !stall_id && !rst;
    assign fetch_halted = (state == HALTED);

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .instr_in    (imem_data),
        .pc_plus2_in (pc_inc(pc)),
        .instr       (if_id_instr),
        .pc_plus2    (if_id_pc_plus2),
        .valid       (if_id_valid)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with program counter, instruction-memory request logic and the IF/ID pipeline register that feeds the control decoder. Handles decode-stage stalls, memory stalls, branch/jump redirects and HALT, inserting NOP bubbles (16'h0800, opcode 00001) whenever no valid instruction is delivered. Sits between instruction memory and the decode stage; its `if_id_instr` output is the decoder's `instr` input.

## Interface
- `PC_RESET`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `imem_addr`  out  16  fetch address (equals PC).
- `imem_rd`  out  1  fetch request.
- `imem_data`  in  16  instruction; valid in any cycle with `imem_rd & !imem_stall`.
- `imem_stall`  in  1  memory not ready this cycle; address must be held.
- `stall_id`  in  1  hazard stall from decode; hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump/JR from a later stage.
- `redirect_pc`  in  16  target PC when `redirect`.
- `halt_id`  in  1  decoder's `halt` for the instruction now in IF/ID.
- `if_id_instr`  out  16  instruction to decoder.
- `if_id_pc_plus2`  out  16  PC+2 of that instruction (for JAL/branches).
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_halted`  out  1  fetch is in HALTED state.

## Operation
- States: RUN, HALTED. Reset -> RUN.
- `imem_rd` = (state==RUN) & !stall_id & !rst. `imem_addr` = PC always.
- Per-edge priority in RUN (first match wins):
  - `redirect`: PC <= `redirect_pc`; IF/ID <= NOP, valid 0; any outstanding access dropped.
  - `stall_id`: PC, IF/ID hold.
  - `halt_id`: state <= HALTED; PC holds; IF/ID <= NOP, valid 0.
  - `imem_stall`: PC holds; IF/ID <= NOP, valid 0.
  - else: IF/ID <= {`imem_data`, PC+2}, valid 1; PC <= PC+2.
- HALTED: `imem_rd`=0, `fetch_halted`=1; PC and IF/ID hold (NOP). `redirect` (older instruction resolving; halt was wrong-path) -> state RUN, PC <= `redirect_pc`. Otherwise only `rst` exits.
- Arithmetic: PC+2 modulo 2^16 (16'hFFFE -> 16'h0000). `redirect_pc` used unmodified, no alignment check.
- `halt_id` with `stall_id` same cycle: stall wins; halt re-evaluated next cycle (instruction still in IF/ID).
- `halt_id` with `redirect` same cycle: redirect wins, no halt.

## Timing
- Reset values: PC=`PC_RESET`, `if_id_instr`=16'h0800, `if_id_pc_plus2`=16'h0000, `if_id_valid`=0, `fetch_halted`=0, state RUN.
- Fetch latency: instruction at `imem_addr` in cycle N appears on `if_id_instr` in cycle N+1 (one register).
- Redirect: asserted in cycle N -> `imem_addr`=`redirect_pc` in N+1; target instruction in IF/ID in N+2; exactly one bubble.
- `imem_addr` stable across every cycle `imem_stall`=1 unless `redirect` fires.
- Reset asserted mid-stall or in HALTED: all state returns to reset values asynchronously; first fetch in the first cycle after deassertion.
- All outputs registered except `imem_rd`, `imem_addr` (PC register directly).

## Structure
- Shared package: `NOP_INSTR`=16'h0800, `OP_HALT`=5'b00000, state enum {RUN, HALTED}, `PC_W`=16.
- One sub-module: `if_id_reg` (instr, pc_plus2, valid; load/hold/flush-to-NOP controls, async reset to NOP/0). PC register and FSM live in `fetch_stage`.

## Test plan
- Reset release, memory returns 16'hA001 @0, 16'hB002 @2, no stalls -> IF/ID: (A001, pc_plus2 0002, valid1), then (B002, 0004); `imem_addr` 0,2,4.
- `imem_stall` high 3 cycles at PC 16'h0004 -> `imem_addr` stays 0004, IF/ID NOP valid0 three cycles, then fetched word with pc_plus2 0006.
- `stall_id` 2 cycles while IF/ID holds 16'h4123 -> IF/ID, PC unchanged, `imem_rd`=0; resumes with next sequential word.
- `redirect`=1, `redirect_pc`=16'h0100 with `stall_id` and `imem_stall` also high -> next cycle `imem_addr`=0100, IF/ID NOP valid0; word @0100 in IF/ID one cycle later.
- `halt_id` at PC 16'h0010 -> `fetch_halted`=1, `imem_rd`=0, IF/ID NOP held 10 cycles; then `redirect` to 16'h0040 -> RUN, fetch @0040; PC at 16'hFFFE wraps to 0000.
- Assert `rst` while HALTED with PC 16'h0020 -> immediately PC=0000, `fetch_halted`=0, IF/ID=0800 valid0, all outputs at reset values.
